// File: rtl/div_issue_ctrl_pkg.sv
// Shared types and constants for the divider issue controller.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    localparam logic [6:0] OPCODE_OP   = 7'b0110011;
    localparam logic [6:0] OPCODE_OP32 = 7'b0111011;

    localparam int unsigned LAT_MAX_DEFAULT = 80;

endpackage

// File: rtl/div_special_case.sv
// Detects divide-by-zero and signed overflow and produces the architectural
// result for them without involving the divider core.
module div_special_case
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic [2:0]        funct3,
    input  logic              word,
    output logic              is_special,
    output logic [DATA_W-1:0] special_result
);

    logic              is_signed;
    logic              is_rem;
    logic              div_by_zero;
    logic              overflow;
    logic [DATA_W-1:0] dividend_ext;
    logic [DATA_W-1:0] quotient;
    logic [DATA_W-1:0] remainder;

    always_comb begin
        is_signed = !funct3[0];
        is_rem    = funct3[1];

        // W-forms judge only the low halves; their results are always sign-extended.
        if (word) begin
            div_by_zero  = (divisor[31:0] == '0);
            overflow     = is_signed && (dividend[31:0] == 32'h8000_0000)
                           && (divisor[31:0] == '1);
            dividend_ext = {{(DATA_W-32){dividend[31]}}, dividend[31:0]};
        end else begin
            div_by_zero  = (divisor == '0);
            overflow     = is_signed && (dividend == {1'b1, {(DATA_W-1){1'b0}}})
                           && (divisor == '1);
            dividend_ext = dividend;
        end

        if (div_by_zero) begin
            quotient  = '1;
            remainder = dividend_ext;
        end else begin
            quotient  = dividend_ext;
            remainder = '0;
        end

        is_special     = funct3[2] && (div_by_zero || overflow);
        special_result = is_rem ? remainder : quotient;
    end

endmodule

// File: rtl/div_issue_ctrl.sv
// Issue controller sequencing RV64M divide/remainder requests through the shared
// divider core. Optional watchdog: define DIV_ISSUE_CTRL_WATCHDOG_EN.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned LAT_MAX = LAT_MAX_DEFAULT
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [DATA_W-1:0] ReqDividend,
    input  logic [DATA_W-1:0] ReqDivisor,
    input  logic [2:0]        ReqFunct3,
    input  logic              ReqWord,
    input  logic [ADDR_W-1:0] ReqWriteAddr,
    input  logic              Flush,
    output logic              CoreStart,
    output logic              CoreKill,
    output logic [DATA_W-1:0] CoreDividend,
    output logic [DATA_W-1:0] CoreDivisor,
    output logic              CoreSigned,
    input  logic              CoreDone,
    input  logic [DATA_W-1:0] CoreQuotient,
    input  logic [DATA_W-1:0] CoreRemainder,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [DATA_W-1:0] RspData,
    output logic [ADDR_W-1:0] RspWriteAddr,
    output logic              RspErr,
    output logic              Busy
);

    state_t            state;
    logic              rem_q;
    logic              word_q;
    logic              accept;
    logic              is_special;
    logic [DATA_W-1:0] special_result;
    logic [DATA_W-1:0] ext_dividend;
    logic [DATA_W-1:0] ext_divisor;
    logic [DATA_W-1:0] core_sel;
    logic [DATA_W-1:0] core_result;

`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
    localparam logic [7:0] WD_LIMIT = 8'(LAT_MAX - 1);
    logic [7:0] wd_cnt;
    logic       wd_fired;
    logic       err_q;
    assign RspErr = err_q;
`else
    assign RspErr = 1'b0;
`endif

    assign ReqReady = (state == IDLE) && !Flush && !Rst;
    assign accept   = ReqValid && ReqReady;
    assign Busy     = (state != IDLE);

    div_special_case #(
        .DATA_W(DATA_W)
    ) u_special (
        .dividend      (ReqDividend),
        .divisor       (ReqDivisor),
        .funct3        (ReqFunct3),
        .word          (ReqWord),
        .is_special    (is_special),
        .special_result(special_result)
    );

    always_comb begin
        if (ReqWord) begin
            ext_dividend = {{(DATA_W-32){!ReqFunct3[0] && ReqDividend[31]}}, ReqDividend[31:0]};
            ext_divisor  = {{(DATA_W-32){!ReqFunct3[0] && ReqDivisor[31]}}, ReqDivisor[31:0]};
        end else begin
            ext_dividend = ReqDividend;
            ext_divisor  = ReqDivisor;
        end
        core_sel    = rem_q ? CoreRemainder : CoreQuotient;
        core_result = word_q ? {{(DATA_W-32){core_sel[31]}}, core_sel[31:0]} : core_sel;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= IDLE;
            rem_q        <= 1'b0;
            word_q       <= 1'b0;
            CoreStart    <= 1'b0;
            CoreKill     <= 1'b0;
            CoreDividend <= '0;
            CoreDivisor  <= '0;
            CoreSigned   <= 1'b0;
            RspValid     <= 1'b0;
            RspData      <= '0;
            RspWriteAddr <= '0;
`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
            wd_cnt       <= '0;
            wd_fired     <= 1'b0;
            err_q        <= 1'b0;
`endif
        end else begin
            CoreStart <= 1'b0;
            CoreKill  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        rem_q        <= ReqFunct3[1];
                        word_q       <= ReqWord;
                        CoreDividend <= ext_dividend;
                        CoreDivisor  <= ext_divisor;
                        CoreSigned   <= !ReqFunct3[0];
                        RspWriteAddr <= ReqWriteAddr;
                        if (is_special) begin
                            RspData  <= special_result;
                            RspValid <= 1'b1;
                            state    <= RESP;
                        end else begin
                            CoreStart <= 1'b1;
                            state     <= RUN;
`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
                            wd_cnt    <= '0;
`endif
                        end
                    end
                end
                RUN: begin
`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
                    wd_cnt <= wd_cnt + 8'd1;
`endif
                    // A done coinciding with a flush means the core is already idle: no kill.
                    if (Flush) begin
                        CoreKill <= !CoreDone;
                        state    <= CoreDone ? IDLE : DRAIN;
                    end else if (CoreDone) begin
                        RspData  <= core_result;
                        RspValid <= 1'b1;
                        state    <= RESP;
                    end
`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
                    else if (wd_cnt == WD_LIMIT) begin
                        CoreKill <= 1'b1;
                        wd_fired <= 1'b1;
                        state    <= DRAIN;
                    end
`endif
                end
                DRAIN: begin
                    if (CoreDone) begin
                        state <= IDLE;
`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
                        if (wd_fired) begin
                            wd_fired <= 1'b0;
                            err_q    <= 1'b1;
                            RspData  <= '0;
                            RspValid <= 1'b1;
                            state    <= RESP;
                        end
`endif
                    end
                end
                RESP: begin
                    if (Flush || RspReady) begin
                        RspValid <= 1'b0;
                        state    <= IDLE;
`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
                        err_q    <= 1'b0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Directed plus randomized checks of div_issue_ctrl against an RV64M result model.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    localparam int unsigned LAT = 80;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic [2:0]  req_funct3;
    logic        req_word;
    logic [4:0]  req_addr;
    logic        flush;
    logic        core_start;
    logic        core_kill;
    logic [63:0] core_dividend;
    logic [63:0] core_divisor;
    logic        core_signed;
    logic        core_done;
    logic [63:0] core_quotient;
    logic [63:0] core_remainder;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_data;
    logic [4:0]  rsp_addr;
    logic        rsp_err;
    logic        busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [63:0] last_data;

    div_issue_ctrl #(
        .DATA_W (64),
        .ADDR_W (5),
        .LAT_MAX(LAT)
    ) dut (
        .Clk          (clk),
        .Rst          (rst),
        .ReqValid     (req_valid),
        .ReqReady     (req_ready),
        .ReqDividend  (req_dividend),
        .ReqDivisor   (req_divisor),
        .ReqFunct3    (req_funct3),
        .ReqWord      (req_word),
        .ReqWriteAddr (req_addr),
        .Flush        (flush),
        .CoreStart    (core_start),
        .CoreKill     (core_kill),
        .CoreDividend (core_dividend),
        .CoreDivisor  (core_divisor),
        .CoreSigned   (core_signed),
        .CoreDone     (core_done),
        .CoreQuotient (core_quotient),
        .CoreRemainder(core_remainder),
        .RspValid     (rsp_valid),
        .RspReady     (rsp_ready),
        .RspData      (rsp_data),
        .RspWriteAddr (rsp_addr),
        .RspErr       (rsp_err),
        .Busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // RISC-V M-extension semantics: returns {special, rd value}.
    function automatic logic [64:0] ref_op(input logic [2:0] f3, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
        logic        sgn, rem, sp;
        logic [31:0] a32, b32, q32, r32, s32;
        logic [63:0] q64, r64, res;
        sgn = !f3[0];
        rem = f3[1];
        sp  = 1'b0;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; r32 = a32; sp = 1'b1;
            end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; r32 = 32'd0; sp = 1'b1;
            end else if (sgn) begin
                q32 = $signed(a32) / $signed(b32);
                r32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32;
                r32 = a32 % b32;
            end
            s32 = rem ? r32 : q32;
            res = {{32{s32[31]}}, s32};
        end else begin
            if (b == 64'd0) begin
                q64 = '1; r64 = a; sp = 1'b1;
            end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; r64 = 64'd0; sp = 1'b1;
            end else if (sgn) begin
                q64 = $signed(a) / $signed(b);
                r64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b;
                r64 = a % b;
            end
            res = rem ? r64 : q64;
        end
        return {sp, res};
    endfunction

    function automatic logic [63:0] ext_op(input logic [2:0] f3, input logic w, input logic [63:0] v);
        if (!w) return v;
        if (!f3[0]) return {{32{v[31]}}, v[31:0]};
        return {32'd0, v[31:0]};
    endfunction

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            4:       return {$urandom, 32'h8000_0000};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Present a request for one cycle; leaves the bench at cycle 1 after the accept.
    task automatic accept(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] addr,
                          output logic sp, output logic [63:0] exp);
        logic [64:0] r;
        r   = ref_op(f3, w, a, b);
        sp  = r[64];
        exp = r[63:0];
        req_valid    = 1'b1;
        req_funct3   = f3;
        req_word     = w;
        req_dividend = a;
        req_divisor  = b;
        req_addr     = addr;
        #1;
        chk("req_ready_idle", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        if (sp) begin
            chk("special_no_start", core_start, 1'b0);
            chk("special_rsp_cycle1", rsp_valid, 1'b1);
        end else begin
            chk("core_start_cycle1", core_start, 1'b1);
            chk("core_dividend", core_dividend, ext_op(f3, w, a));
            chk("core_divisor", core_divisor, ext_op(f3, w, b));
            chk("core_signed", core_signed, !f3[0]);
        end
    endtask

    task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] addr,
                         input int unsigned lat, input int unsigned hold);
        logic        sp;
        logic [63:0] exp, ea, eb;
        accept(f3, w, a, b, addr, sp, exp);
        if (!sp) begin
            ea = ext_op(f3, w, a);
            eb = ext_op(f3, w, b);
            repeat (lat - 1) begin
                step();
                chk("start_single_pulse", core_start, 1'b0);
                chk("no_rsp_while_run", rsp_valid, 1'b0);
            end
            core_done = 1'b1;
            if (!f3[0]) begin
                core_quotient  = $signed(ea) / $signed(eb);
                core_remainder = $signed(ea) % $signed(eb);
            end else begin
                core_quotient  = ea / eb;
                core_remainder = ea % eb;
            end
            step();
            core_done      = 1'b0;
            core_quotient  = {$urandom, $urandom};
            core_remainder = {$urandom, $urandom};
            chk("rsp_valid_after_done", rsp_valid, 1'b1);
        end
        chk("rsp_data", rsp_data, exp);
        chk("rsp_addr", rsp_addr, addr);
        chk("rsp_err_clear", rsp_err, 1'b0);
        last_data = rsp_data;
        repeat (hold) begin
            step();
            chk("rsp_hold_valid", rsp_valid, 1'b1);
            chk("rsp_hold_data", rsp_data, exp);
            chk("req_ready_in_resp", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("rsp_released", rsp_valid, 1'b0);
        chk("idle_after_rsp", busy, 1'b0);
    endtask

    initial begin
        logic        sp;
        logic [63:0] exp;

        rst = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        req_funct3 = '0; req_word = 1'b0; req_addr = '0; flush = 1'b0;
        core_done = 1'b0; core_quotient = '0; core_remainder = '0; rsp_ready = 1'b0;
        last_data = '0;
        repeat (2) step();
        chk("rst_core_start", core_start, 1'b0);
        chk("rst_core_kill", core_kill, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_data", rsp_data, 64'd0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_core_dividend", core_dividend, 64'd0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", req_ready, 1'b1);
        step();

        do_op(FUNCT3_DIVU, 1'b0, 64'd100, 64'd7, 5'd3, 64, 0);
        chk("divu_100_7", last_data, 64'd14);
        do_op(FUNCT3_REM, 1'b0, -64'sd7, 64'd2, 5'd5, 6, 0);
        chk("rem_m7_2", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(FUNCT3_DIV, 1'b0, 64'd5, 64'd0, 5'd6, 1, 0);
        chk("div_by_zero", last_data, 64'hFFFF_FFFF_FFFF_FFFF);
        do_op(FUNCT3_REM, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 5'd7, 1, 0);
        chk("remw_overflow", last_data, 64'd0);
        do_op(FUNCT3_DIV, 1'b1, 64'h8000_0000, '1, 5'd8, 1, 0);
        chk("divw_overflow", last_data, 64'hFFFF_FFFF_8000_0000);
        do_op(FUNCT3_DIVU, 1'b1, 64'hFFFF_FFFE, 64'd1, 5'd9, 4, 0);
        chk("divuw_sext", last_data, 64'hFFFF_FFFF_FFFF_FFFE);
        do_op(FUNCT3_REMU, 1'b0, 64'd1000, 64'd33, 5'd10, 3, 5);
        chk("remu_hold", last_data, 64'd10);

        // Flush during RUN: kill, drain the late done, no response.
        accept(FUNCT3_DIVU, 1'b0, 64'd1000, 64'd10, 5'd11, sp, exp);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_kill", core_kill, 1'b1);
        chk("flush_no_start", core_start, 1'b0);
        chk("flush_drain_busy", busy, 1'b1);
        step();
        chk("kill_single_pulse", core_kill, 1'b0);
        chk("drain_not_ready", req_ready, 1'b0);
        repeat (3) step();
        core_done = 1'b1; core_quotient = 64'd100; core_remainder = 64'd0;
        step();
        core_done = 1'b0;
        chk("drain_no_rsp", rsp_valid, 1'b0);
        chk("drain_to_idle", busy, 1'b0);
        step();
        chk("drain_still_no_rsp", rsp_valid, 1'b0);
        do_op(FUNCT3_DIV, 1'b0, 64'd77, 64'd7, 5'd12, 5, 0);
        chk("after_flush_op", last_data, 64'd11);

        // Flush and done together in RUN: straight to IDLE, no kill.
        accept(FUNCT3_DIV, 1'b0, 64'd50, 64'd5, 5'd13, sp, exp);
        step();
        flush = 1'b1; core_done = 1'b1; core_quotient = 64'd10;
        step();
        flush = 1'b0; core_done = 1'b0;
        chk("flushdone_idle", busy, 1'b0);
        chk("flushdone_no_kill", core_kill, 1'b0);
        chk("flushdone_no_rsp", rsp_valid, 1'b0);
        step();
        chk("flushdone_no_kill_later", core_kill, 1'b0);

        // Flush in RESP drops the response.
        accept(FUNCT3_DIV, 1'b0, 64'd5, 64'd0, 5'd14, sp, exp);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("resp_flush_drop", rsp_valid, 1'b0);
        chk("resp_flush_idle", busy, 1'b0);

        // Flush in IDLE blocks acceptance; stray done in IDLE is ignored.
        req_valid = 1'b1; req_funct3 = FUNCT3_DIV; req_dividend = 64'd9; req_divisor = 64'd3;
        flush = 1'b1;
        #1;
        chk("idle_flush_not_ready", req_ready, 1'b0);
        step();
        req_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_no_accept", busy, 1'b0);
        chk("idle_flush_no_start", core_start, 1'b0);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("stray_done_ignored", rsp_valid, 1'b0);
        chk("stray_done_idle", busy, 1'b0);

        // Reset mid-RUN returns to IDLE without a kill.
        accept(FUNCT3_REMU, 1'b0, 64'd40, 64'd6, 5'd15, sp, exp);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_idle", busy, 1'b0);
        chk("rst_mid_no_kill", core_kill, 1'b0);
        chk("rst_mid_no_start", core_start, 1'b0);

        for (int i = 0; i < 40; i++) begin
            do_op(3'(4 + $urandom_range(0, 3)), 1'($urandom_range(0, 1)), pick_val(), pick_val(),
                  5'($urandom_range(0, 31)), $urandom_range(1, 8), $urandom_range(0, 3));
        end

`ifdef DIV_ISSUE_CTRL_WATCHDOG_EN
        accept(FUNCT3_DIVU, 1'b0, 64'd9, 64'd3, 5'd21, sp, exp);
        repeat (LAT - 1) step();
        chk("wd_no_early_kill", core_kill, 1'b0);
        step();
        chk("wd_kill", core_kill, 1'b1);
        chk("wd_drain_busy", busy, 1'b1);
        step();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        chk("wd_rsp_valid", rsp_valid, 1'b1);
        chk("wd_rsp_err", rsp_err, 1'b1);
        chk("wd_rsp_data", rsp_data, 64'd0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("wd_idle", busy, 1'b0);
        chk("wd_err_cleared", rsp_err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Issue controller for the shared multi-cycle divider core. Accepts one RV64M divide/remainder request at a time from Ex over a valid/ready handshake and resolves divide-by-zero and signed overflow locally without starting the core. All other requests are sequenced through the core with start, kill and done signals. The result is returned on a held response port to Ex/WB, and a busy flag drives the Ctrl stall logic.

## Interface
Parameters:
- DATA_W, 64, operand/result width
- ADDR_W, 5, register-file write-address width
- LAT_MAX, 80, watchdog limit in cycles spent in RUN (used only with watchdog compiled in)

Ports (one clock; reset is synchronous and active-high):
- Clk  in  1  clock; all state updates on rising edge
- Rst  in  1  synchronous active-high reset
- ReqValid  in  1  request present
- ReqReady  out  1  request accepted when ReqValid && ReqReady
- ReqDividend  in  DATA_W  rs1 value
- ReqDivisor  in  DATA_W  rs2 value
- ReqFunct3  in  3  100 div, 101 divu, 110 rem, 111 remu
- ReqWord  in  1  W-form (opcode 0111011)
- ReqWriteAddr  in  ADDR_W  destination register
- Flush  in  1  pipeline flush; abandons the in-flight operation
- CoreStart  out  1  one-cycle start pulse to the core
- CoreKill  out  1  one-cycle abort pulse to the core
- CoreDividend, CoreDivisor  out  DATA_W  registered operands; W-forms are sign- or zero-extended from bit 31 per signedness
- CoreSigned  out  1  funct3[0]==0
- CoreDone  in  1  core result valid, one cycle
- CoreQuotient, CoreRemainder  in  DATA_W  core results
- RspValid  out  1  response valid; held until RspReady
- RspReady  in  1  consumer accepts the response
- RspData  out  DATA_W  final rd value
- RspWriteAddr  out  ADDR_W  destination register
- RspErr  out  1  watchdog expired; RspData is 0
- Busy  out  1  state != IDLE; goes to Ctrl

## Operation
- States: IDLE, RUN, DRAIN, RESP.
- Reset: state IDLE; every output 0; internal registers 0.
- ReqReady = (state==IDLE) && !Flush.
- IDLE with accept:
  - Latch operands, funct3, word and address.
  - If special, compute the result, load it into the response register, and go to RESP.
  - Otherwise pulse CoreStart on the next cycle and go to RUN.
- Special cases are evaluated on the 32-bit low halves for W-forms and on the full width otherwise:
  - Divisor zero: quotient all ones, remainder = dividend.
  - Signed, dividend = most-negative value, divisor = -1: quotient = dividend, remainder 0.
- RUN:
  - On CoreDone, select remainder if funct3[1], else quotient. W-forms sign-extend the selected value from bit 31.
  - Register the value into RspData and go to RESP.
- RESP: RspValid=1 with stable RspData/RspWriteAddr. On RspReady, go to IDLE.
- Flush:
  - In RUN: pulse CoreKill and go to DRAIN.
  - In RESP: drop the response and go to IDLE.
  - In IDLE: blocks acceptance.
  - In DRAIN: no effect.
- DRAIN: wait for CoreDone, discard it, then go to IDLE. This prevents a stale done from matching the next request.
- CoreDone outside RUN/DRAIN is ignored.
- Flush and CoreDone in the same RUN cycle: Flush wins; no response; go to IDLE directly (the core is already finished, so no kill).
- Rst in any state goes to IDLE in the next cycle. CoreKill is not pulsed; the core is reset by the same Rst.

## Timing
- Cycle 0: accept.
- Special case: RspValid at cycle 1.
- Normal case: CoreStart at cycle 1. CoreDone at cycle k gives RspValid at cycle k+1.
- Back-to-back: RspReady at cycle n gives IDLE at n+1; the next accept is at n+1 at the earliest.
- RspValid and RspData do not change while RspValid && !RspReady.
- CoreStart and CoreKill are never asserted in the same cycle. Each is high for exactly one cycle.

## Configuration
- DIV_ISSUE_CTRL_WATCHDOG_EN defined:
  - An 8-bit counter clears on entry to RUN and increments each RUN cycle.
  - When it reaches LAT_MAX without CoreDone: pulse CoreKill, go to DRAIN, then present a RESP with RspErr=1 and RspData=0.
- Undefined: counter absent, RspErr tied 0, RUN waits indefinitely.

## Structure
- Package div_issue_ctrl_pkg holds:
  - the state encoding (2-bit enum IDLE/RUN/DRAIN/RESP);
  - FUNCT3_DIV/DIVU/REM/REMU constants;
  - OPCODE_OP/OPCODE_OP32;
  - default LAT_MAX.
- Sub-module div_special_case: combinational detection plus special result generation, taking operands, funct3 and word; it outputs is_special and special_result.
- Sequential FSM, operand/response registers and the watchdog live in the top.

## Test plan
- divu 100/7, core done after 64 cycles -> CoreStart at cycle 1; RspData=14 at cycle 65.
- rem -7/2 full width -> core path; RspData=0xFFFF_FFFF_FFFF_FFFF (-1).
- div by 0, dividend 5 -> no CoreStart; RspValid at cycle 1; RspData=all ones. remw 0x8000_0000/0xFFFF_FFFF -> RspData=0.
- divw 0x8000_0000 / -1 -> RspData=0xFFFF_FFFF_8000_0000, special path. divuw 0xFFFF_FFFE/1 -> RspData=0xFFFF_FFFF_FFFF_FFFE (sign-extended).
- Flush at RUN cycle 10 -> CoreKill pulse, DRAIN. A late CoreDone is discarded and no RspValid follows. The next request is served correctly.
- RspReady held 0 for 5 cycles -> RspData stable and ReqReady 0. With the watchdog enabled, CoreDone never arrives and LAT_MAX=80 -> RspErr=1 after the kill.
